act_skew_feeder: RTL and testbench
==================================

// Module: act_skew_feeder
// PURPOSE
//  Upstream activation feeder for the weight-stationary PE array.
//  Accepts one activation vector per cycle (one element per array row) over a valid/ready handshake.
//  Skews the vector so row i sees its element i cycles after row 0, and drives active_left and w_compute into the array.
//  Sequences one tile pass: IDLE -> FEED (num_vectors vectors) -> DRAIN (skew flush) -> done pulse.
// PARAMETERS
//  data_width       19  bits per activation element
//  a_tile_row_size  14  PE array rows = elements per vector = skew depth
//  cnt_width         8  width of the vector counter and num_vectors
// PORTS
//  clk            in   1                          single clock, rising edge
//  rst            in   1                          asynchronous, active-high reset
//  start          in   1                          pulse: begin a tile pass (ignored unless IDLE)
//  num_vectors    in   cnt_width                  vectors in this pass, sampled on accepted start
//  in_valid       in   1                          in_act holds a vector
//  in_ready       out  1                          feeder accepts a vector this cycle
//  in_act         in   data_width*a_tile_row_size element i at [(i+1)*data_width-1 : i*data_width]
//  active_left    out  data_width*a_tile_row_size skewed row activations to the PE array
//  active_valid   out  a_tile_row_size            bit i: active_left row i carries a real element
//  w_compute      out  1                          compute enable to the PE array
//  busy           out  1                          high in FEED and DRAIN
//  done           out  1                          one-cycle pulse at the end of a pass
// BEHAVIOUR
//  Reset (async, any time, including mid-pass):
//   - state -> IDLE; counters -> 0; all skew registers and valid bits -> 0.
//   - in_ready, w_compute, busy, done, active_left, active_valid all read 0.
//   - A partially fed pass is discarded.
//  FSM:
//   - IDLE: start && num_vectors!=0 -> FEED. start && num_vectors==0 -> done=1 next cycle, stay IDLE.
//   - FEED: in_ready=1. Accept = in_valid && in_ready. Count accepts. On the accept where count==num_vectors-1 -> DRAIN.
//   - DRAIN: in_ready=0. Lasts exactly a_tile_row_size cycles, then -> IDLE with done=1 for one cycle.
//  Skew datapath:
//   - Row i is a chain of i+1 registers, each paired with a valid bit.
//   - Vector accepted at cycle t: element i appears on active_left row i at t+1+i with active_valid[i]=1.
//   - Any cycle without an accept (FEED with in_valid=0, or DRAIN) shifts zero data with valid=0 into every row head.
//   - Consequence: stalls become aligned zero bubbles; partial sums stay diagonally consistent.
//   - Registers shift every cycle in FEED and DRAIN and hold in IDLE.
//  Control outputs:
//   - w_compute = busy, asserted from the first FEED cycle through the last DRAIN cycle.
//   - With last accept at t_L: row a_tile_row_size-1 is valid at t_L+a_tile_row_size; done pulses at t_L+a_tile_row_size+1.
//  Boundaries:
//   - start while busy: ignored, num_vectors not resampled.
//   - num_vectors=1: FEED lasts until the single accept.
//   - The counter never wraps, since num_vectors <= 2^cnt_width-1.
//   - in_act is not sampled when in_ready=0.
//   - Data passes through unmodified: no arithmetic, no width change.
// TESTING
//  1. Reset during DRAIN at an arbitrary cycle -> all outputs 0 at once; next start runs a clean pass.
//  2. rows=14, num_vectors=1, in_act row i = i+1, in_valid held high:
//     -> row i equals i+1 exactly at t+1+i; done at t+15; busy high for 15 cycles.
//  3. num_vectors=3, in_valid low for 2 cycles between vector 1 and vector 2:
//     -> 2-cycle zero bubble on every row, diagonally aligned; valid bits low in the bubble; done at t_L+15.
//  4. start with num_vectors=0 -> done for exactly 1 cycle; in_ready, w_compute and busy stay 0.
//  5. start pulsed during FEED with a different num_vectors -> pass length unchanged; exactly one done.
//  6. Random streams with random in_valid gaps, checked against a software skew model:
//     -> active_left/active_valid match cycle-exactly; accept count equals num_vectors.

Source files
------------

// File: rtl/act_skew_feeder_if.sv
// Activation input stream between the upstream producer and the skew feeder.
//   in_valid : producer has a vector on in_act
//   in_ready : feeder accepts the vector this cycle
//   in_act   : packed vector, element i at [(i+1)*data_width-1 : i*data_width]
// master = producer side, slave = feeder side.
interface act_skew_if #(
    parameter int unsigned data_width      = 19,
    parameter int unsigned a_tile_row_size = 14
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [data_width*a_tile_row_size-1:0]   in_act;

    modport master (output in_valid, output in_act, input in_ready);
    modport slave  (input in_valid, input in_act, output in_ready);
endinterface

// File: rtl/act_skew_feeder.sv
// Upstream activation feeder for the weight-stationary PE array.
// Accepts one vector per cycle, skews it so row i sees its element i cycles after
// row 0, and sequences one tile pass: IDLE -> FEED -> DRAIN -> done pulse.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a pass (only honoured in IDLE)
//   num_vectors  : vectors in the pass, sampled on an accepted start
//   in_if        : input vector stream (valid/ready/act)
//   active_left  : skewed row activations to the array
//   active_valid : per-row flag, row carries a real element
//   w_compute    : compute enable to the array (same as busy)
//   busy         : high in FEED and DRAIN
//   done         : one-cycle pulse at the end of a pass
module act_skew_feeder #(
    parameter int unsigned data_width      = 19,
    parameter int unsigned a_tile_row_size = 14,
    parameter int unsigned cnt_width       = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [cnt_width-1:0]                  num_vectors,
    act_skew_if.slave                             in_if,
    output logic [data_width*a_tile_row_size-1:0] active_left,
    output logic [a_tile_row_size-1:0]            active_valid,
    output logic                                  w_compute,
    output logic                                  busy,
    output logic                                  done
);

    localparam int unsigned drain_w = (a_tile_row_size > 1) ? $clog2(a_tile_row_size) : 1;
    localparam logic [drain_w-1:0] drain_last = drain_w'(a_tile_row_size - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN
    } state_t;

    state_t               state;
    logic [cnt_width-1:0] vec_cnt;
    logic [cnt_width-1:0] num_vec_q;
    logic [drain_w-1:0]   drain_cnt;
    logic                 in_ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 accept;
    logic                 shift_en;

    assign accept    = in_if.in_valid && in_ready_q;
    // Skew chains advance on every FEED/DRAIN cycle and hold in IDLE.
    assign shift_en  = busy_q;

    assign in_if.in_ready = in_ready_q;
    assign busy           = busy_q;
    assign w_compute      = busy_q;
    assign done           = done_q;

    // Pass sequencer with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec_cnt    <= '0;
            num_vec_q  <= '0;
            drain_cnt  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_vectors == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            num_vec_q  <= num_vectors;
                            vec_cnt    <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state      <= ST_FEED;
                        end
                    end
                end
                ST_FEED: begin
                    if (accept) begin
                        if (vec_cnt == num_vec_q - cnt_width'(1)) begin
                            vec_cnt    <= '0;
                            drain_cnt  <= '0;
                            in_ready_q <= 1'b0;
                            state      <= ST_DRAIN;
                        end else begin
                            vec_cnt <= vec_cnt + cnt_width'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Exactly a_tile_row_size cycles flush the deepest row.
                    if (drain_cnt == drain_last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + drain_w'(1);
                    end
                end
                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Row r: chain of r+1 data/valid registers; non-accept cycles inject zero bubbles.
    for (genvar r = 0; r < a_tile_row_size; r++) begin : g_row
        logic [data_width-1:0] d_q [r+1];
        logic                  v_q [r+1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) begin
                    d_q[j] <= '0;
                    v_q[j] <= 1'b0;
                end
            end else if (shift_en) begin
                d_q[0] <= accept ? in_if.in_act[r*data_width +: data_width] : '0;
                v_q[0] <= accept;
                for (int j = 1; j <= r; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign active_left[r*data_width +: data_width] = d_q[r];
        assign active_valid[r]                         = v_q[r];
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Self-checking bench for act_skew_feeder: table-driven single-vector pass plus
// directed corner sequences and random streams checked against a history model.
module tb_act_skew_feeder;

    localparam int unsigned DW   = 19;
    localparam int unsigned ROWS = 14;
    localparam int unsigned CW   = 8;
    localparam int unsigned VW   = DW * ROWS;
    localparam int unsigned HD   = ROWS + 2;

    logic            clk;
    logic            rst;
    logic            start;
    logic [CW-1:0]   num_vectors;
    logic [VW-1:0]   active_left;
    logic [ROWS-1:0] active_valid;
    logic            w_compute;
    logic            busy;
    logic            done;

    act_skew_if #(.data_width(DW), .a_tile_row_size(ROWS)) bus ();

    act_skew_feeder #(.data_width(DW), .a_tile_row_size(ROWS), .cnt_width(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_vectors  (num_vectors),
        .in_if        (bus),
        .active_left  (active_left),
        .active_valid (active_valid),
        .w_compute    (w_compute),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: per-edge history of accepted vectors (index 0 = most recent edge)
    logic [VW-1:0] h_d [HD];
    logic          h_v [HD];
    int unsigned   m_left, m_drain;
    logic          m_ready, m_busy, m_done;

    int unsigned   cyc;
    int unsigned   dut_acc_cnt, dut_done_cnt;
    int unsigned   last_acc_cyc, last_done_cyc;

    typedef struct {
        logic            start;
        logic [CW-1:0]   nv;
        logic            vld;
        logic            exp_ready;
        logic            exp_busy;
        logic            exp_done;
        logic [ROWS-1:0] exp_valid;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < HD; k++) begin
            h_d[k] = '0;
            h_v[k] = 1'b0;
        end
        m_left = 0; m_drain = 0;
        m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_update(input logic st, input logic [CW-1:0] nv, input logic vld,
                                input logic [VW-1:0] act);
        logic acc;
        logic done_n;
        acc    = vld && m_ready;
        done_n = 1'b0;
        for (int k = HD - 1; k > 0; k--) begin
            h_d[k] = h_d[k-1];
            h_v[k] = h_v[k-1];
        end
        h_d[0] = acc ? act : '0;
        h_v[0] = acc;
        if (acc) last_acc_cyc = cyc;
        if (!m_busy) begin
            if (st) begin
                if (nv == 0) done_n = 1'b1;
                else begin
                    m_left  = nv;
                    m_ready = 1'b1;
                    m_busy  = 1'b1;
                end
            end
        end else if (m_ready) begin
            if (acc) begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b0;
                    m_drain = ROWS;
                end
            end
        end else begin
            m_drain--;
            if (m_drain == 0) begin
                m_busy = 1'b0;
                done_n = 1'b1;
            end
        end
        m_done = done_n;
    endtask

    task automatic check_model();
        logic [VW-1:0]   exp_l;
        logic [ROWS-1:0] exp_v;
        logic [VW-1:0]   hv;
        exp_l = '0;
        exp_v = '0;
        for (int i = 0; i < ROWS; i++) begin
            hv = h_d[i];
            exp_v[i] = h_v[i];
            if (h_v[i]) exp_l[i*DW +: DW] = hv[i*DW +: DW];
        end
        check("in_ready",     VW'(bus.in_ready), VW'(m_ready));
        check("busy",         VW'(busy),         VW'(m_busy));
        check("w_compute",    VW'(w_compute),    VW'(m_busy));
        check("done",         VW'(done),         VW'(m_done));
        check("active_valid", VW'(active_valid), VW'(exp_v));
        check("active_left",  active_left,       exp_l);
    endtask

    // One clock: drive inputs, clock edge, sample 1 ns later, advance model and compare.
    task automatic step(input logic st, input logic [CW-1:0] nv, input logic vld,
                        input logic [VW-1:0] act);
        start = st;
        num_vectors = nv;
        bus.in_valid = vld;
        bus.in_act = act;
        if (vld && bus.in_ready) dut_acc_cnt++;
        @(posedge clk);
        #1;
        model_update(st, nv, vld, act);
        cyc++;
        if (done) begin
            dut_done_cnt++;
            last_done_cyc = cyc;
        end
        check_model();
    endtask

    task automatic run_pass(input logic [CW-1:0] nv, input int unsigned gap_pct, input logic noisy_start);
        int unsigned a0, d0;
        a0 = dut_acc_cnt;
        d0 = dut_done_cnt;
        step(1'b1, nv, 1'b0, rand_vec());
        for (int k = 0; k < 400 && m_busy; k++)
            step(noisy_start ? 1'($urandom_range(1)) : 1'b0, CW'($urandom),
                 $urandom_range(99) >= gap_pct, rand_vec());
        if (m_busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL pass_timeout: pass of %0d vectors still busy after 400 cycles", nv);
        end
        check("accept_count", VW'(dut_acc_cnt - a0), VW'(nv));
        check("done_count",   VW'(dut_done_cnt - d0), VW'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  VW'(bus.in_ready), '0);
        check({tag, "_busy"},      VW'(busy), '0);
        check({tag, "_w_compute"}, VW'(w_compute), '0);
        check({tag, "_done"},      VW'(done), '0);
        check({tag, "_valid"},     VW'(active_valid), '0);
        check({tag, "_left"},      active_left, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [VW-1:0] ramp;
        logic [VW-1:0] exp_l;
        int unsigned   d0, a0;

        rst = 1'b1;
        start = 1'b0;
        num_vectors = '0;
        bus.in_valid = 1'b0;
        bus.in_act = '0;
        cyc = 0; dut_acc_cnt = 0; dut_done_cnt = 0;
        last_acc_cyc = 0; last_done_cyc = 0;
        model_clear();

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Single vector, row i = i+1, in_valid held high
        for (int i = 0; i < ROWS; i++) ramp[i*DW +: DW] = DW'(i + 1);
        for (int k = 0; k < 17; k++) begin
            tbl[k].start     = (k == 0);
            tbl[k].nv        = CW'(1);
            tbl[k].vld       = 1'b1;
            tbl[k].exp_ready = (k == 0);
            tbl[k].exp_busy  = (k <= 14);
            tbl[k].exp_done  = (k == 15);
            tbl[k].exp_valid = (k >= 1 && k <= 14) ? ROWS'(1) << (k - 1) : '0;
        end
        for (int k = 0; k < 17; k++) begin
            start = tbl[k].start;
            num_vectors = tbl[k].nv;
            bus.in_valid = tbl[k].vld;
            bus.in_act = ramp;
            @(posedge clk);
            #1;
            exp_l = '0;
            for (int i = 0; i < ROWS; i++)
                if (tbl[k].exp_valid[i]) exp_l[i*DW +: DW] = DW'(i + 1);
            check($sformatf("t%0d_in_ready", k),  VW'(bus.in_ready),  VW'(tbl[k].exp_ready));
            check($sformatf("t%0d_busy", k),      VW'(busy),          VW'(tbl[k].exp_busy));
            check($sformatf("t%0d_w_compute", k), VW'(w_compute),     VW'(tbl[k].exp_busy));
            check($sformatf("t%0d_done", k),      VW'(done),          VW'(tbl[k].exp_done));
            check($sformatf("t%0d_valid", k),     VW'(active_valid),  VW'(tbl[k].exp_valid));
            check($sformatf("t%0d_left", k),      active_left,        exp_l);
        end
        model_clear();

        // num_vectors = 0: only a done pulse
        d0 = dut_done_cnt;
        step(1'b1, CW'(0), 1'b1, rand_vec());
        step(1'b0, CW'(0), 1'b1, rand_vec());
        step(1'b0, CW'(0), 1'b0, rand_vec());
        check("nv0_done_count", VW'(dut_done_cnt - d0), VW'(1));

        // Three vectors with a two-cycle bubble after the first
        step(1'b1, CW'(3), 1'b0, rand_vec());
        step(1'b0, CW'(0), 1'b1, rand_vec());
        step(1'b0, CW'(0), 1'b0, rand_vec());
        step(1'b0, CW'(0), 1'b0, rand_vec());
        step(1'b0, CW'(0), 1'b1, rand_vec());
        step(1'b0, CW'(0), 1'b1, rand_vec());
        for (int k = 0; k < 18; k++) step(1'b0, CW'(0), 1'b0, rand_vec());
        check("bubble_done_latency", VW'(last_done_cyc - last_acc_cyc), VW'(ROWS + 1));

        // start re-pulsed during FEED with a different count
        d0 = dut_done_cnt;
        a0 = dut_acc_cnt;
        step(1'b1, CW'(4), 1'b0, rand_vec());
        step(1'b0, CW'(0), 1'b1, rand_vec());
        step(1'b1, CW'(9), 1'b1, rand_vec());
        step(1'b1, CW'(2), 1'b0, rand_vec());
        for (int k = 0; k < 24; k++) step(1'b0, CW'(0), 1'b1, rand_vec());
        check("restart_accepts", VW'(dut_acc_cnt - a0), VW'(4));
        check("restart_dones",   VW'(dut_done_cnt - d0), VW'(1));

        // Asynchronous reset in the middle of DRAIN
        step(1'b1, CW'(2), 1'b0, rand_vec());
        step(1'b0, CW'(0), 1'b1, rand_vec());
        step(1'b0, CW'(0), 1'b1, rand_vec());
        for (int k = 0; k < 5; k++) step(1'b0, CW'(0), 1'b0, rand_vec());
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        run_pass(CW'(3), 30, 1'b0);

        // Random streams with random gaps and stray start pulses
        for (int p = 0; p < 8; p++)
            run_pass(CW'($urandom_range(8, 1)), $urandom_range(60), 1'b1);
        run_pass(CW'(1), 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
